// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - store type codes and FSM state encodings for the store path
package store_unit_pkg;

    localparam logic [2:0] ST_SB = 3'b000;
    localparam logic [2:0] ST_SH = 3'b001;
    localparam logic [2:0] ST_SW = 3'b010;
    localparam logic [2:0] ST_SD = 3'b011;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - combinational lane alignment of store data and byte enables over two bus words
module store_align
    import store_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OB = $clog2(NB)
) (
    input  logic [2:0]        i_type,
    input  logic [OB-1:0]     i_off,
    input  logic [XLEN-1:0]   i_data,
    output logic [2*NB-1:0]   o_wide_be,
    output logic [2*XLEN-1:0] o_wide_data,
    output logic              o_size_illegal
);

    logic [7:0]      w_m8;
    logic [NB-1:0]   w_be_nb;
    logic [XLEN-1:0] w_data_m;

    always_comb begin
        w_m8 = 8'h00;
        case (i_type)
            ST_SB:   w_m8 = 8'h01;
            ST_SH:   w_m8 = 8'h03;
            ST_SW:   w_m8 = 8'h0F;
            ST_SD:   w_m8 = 8'hFF;
            default: w_m8 = 8'h00;
        endcase
        o_size_illegal = i_type[2] | ((i_type == ST_SD) && (XLEN == 32));
        w_be_nb = w_m8[NB-1:0];
        // bytes beyond the access size are forced to zero before shifting
        w_data_m = '0;
        for (int i = 0; i < NB; i++) begin
            w_data_m[8*i +: 8] = w_be_nb[i] ? i_data[8*i +: 8] : 8'h00;
        end
        o_wide_be   = {{NB{1'b0}}, w_be_nb} << i_off;
        o_wide_data = {{XLEN{1'b0}}, w_data_m} << {i_off, 3'b000};
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store request to data-memory beats, splitting word-crossing stores in two
module store_unit
    import store_unit_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1,
    localparam int NB = XLEN / 8,
    localparam int OB = $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [2:0]      st_type,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_data,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [NB-1:0]   mem_be,
    output logic [XLEN-1:0] mem_wdata,
    output logic            st_done,
    output logic            st_err
);

    logic [1:0]        r_state;
    logic [XLEN-1:0]   r_addr;
    logic [NB-1:0]     r_be;
    logic [XLEN-1:0]   r_wdata;
    logic [NB-1:0]     r_hi_be;
    logic [XLEN-1:0]   r_hi_wdata;
    logic              r_split;
    logic              r_done;
    logic              r_err;

    logic [2*NB-1:0]   w_wide_be;
    logic [2*XLEN-1:0] w_wide_data;
    logic              w_size_illegal;
    logic              w_split;
    logic              w_illegal;

    store_align #(.XLEN(XLEN)) u_align (
        .i_type         (st_type),
        .i_off          (st_addr[OB-1:0]),
        .i_data         (st_data),
        .o_wide_be      (w_wide_be),
        .o_wide_data    (w_wide_data),
        .o_size_illegal (w_size_illegal)
    );

    assign w_split   = |w_wide_be[2*NB-1:NB];
    assign w_illegal = w_size_illegal | (w_split & (ALLOW_MISALIGNED == 1'b0));

    assign st_ready  = (r_state == S_IDLE) && !rst;
    assign mem_valid = (r_state != S_IDLE);
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign st_done   = r_done;
    assign st_err    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_hi_be    <= '0;
            r_hi_wdata <= '0;
            r_split    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (st_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state    <= S_BEAT0;
                            r_addr     <= {st_addr[XLEN-1:OB], {OB{1'b0}}};
                            r_be       <= w_wide_be[NB-1:0];
                            r_wdata    <= w_wide_data[XLEN-1:0];
                            r_hi_be    <= w_wide_be[2*NB-1:NB];
                            r_hi_wdata <= w_wide_data[2*XLEN-1:XLEN];
                            r_split    <= w_split;
                        end
                    end
                end
                S_BEAT0: begin
                    if (mem_ready) begin
                        if (r_split) begin
                            // second word address wraps naturally at the top of memory
                            r_state <= S_BEAT1;
                            r_addr  <= r_addr + XLEN'(NB);
                            r_be    <= r_hi_be;
                            r_wdata <= r_hi_wdata;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_BEAT1: begin
                    if (mem_ready) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
